// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer: state encoding,
// product prices, credit width and the coin decoder.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDITO  = 2'd1,
        ST_DISPENSA = 2'd2,
        ST_CAMBIO   = 2'd3
    } state_e;

    localparam int CREDIT_W = 5;
    localparam int STOCK_W  = 3;
    localparam int NUM_PROD = 3;

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = 5'd31;
    localparam logic [CREDIT_W-1:0] COST_A     = 5'd4;
    localparam logic [CREDIT_W-1:0] COST_B     = 5'd7;
    localparam logic [CREDIT_W-1:0] COST_C     = 5'd9;

    // Coin codes 0 and 1 are not legal coins and decode to a zero value.
    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
        logic [CREDIT_W-1:0] val;
        case (code)
            2'd2:    val = 5'd2;
            2'd3:    val = 5'd3;
            default: val = 5'd0;
        endcase
        return val;
    endfunction

    function automatic logic [CREDIT_W-1:0] product_cost(input logic [1:0] sel);
        logic [CREDIT_W-1:0] cost;
        case (sel)
            2'b01:   cost = COST_A;
            2'b10:   cost = COST_B;
            2'b11:   cost = COST_C;
            default: cost = 5'd0;
        endcase
        return cost;
    endfunction

endpackage

// File: rtl/vend_if.sv
// Customer, motor and payout signals of the vending sequencer.
interface vend_if;
    import vend_pkg::*;

    logic [1:0]          moneda;
    logic                moneda_valid;
    logic [1:0]          seleccion;
    logic                sel_valid;
    logic                cancelar;
    logic                restock;
    logic                motor_req;
    logic                motor_ack;
    logic                coin_req;
    logic                coin_ack;
    logic [1:0]          producto;
    logic [CREDIT_W-1:0] credito;
    logic                listo;
    logic                coin_reject;
    logic                agotado;
    logic                fondos_insuf;

    modport master (
        output moneda, moneda_valid, seleccion, sel_valid, cancelar, restock,
               motor_ack, coin_ack,
        input  motor_req, coin_req, producto, credito, listo, coin_reject,
               agotado, fondos_insuf
    );

    modport slave (
        input  moneda, moneda_valid, seleccion, sel_valid, cancelar, restock,
               motor_ack, coin_ack,
        output motor_req, coin_req, producto, credito, listo, coin_reject,
               agotado, fondos_insuf
    );
endinterface

// File: rtl/vend_stock.sv
// Per-product stock counters: decrement on a sale, reload on restock
// (restock wins over a same-cycle sale), and empty flags.
module vend_stock
    import vend_pkg::*;
#(
    parameter int STOCK_MAX = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                restock,
    input  logic                dec,
    input  logic [1:0]          dec_sel,
    output logic [NUM_PROD-1:0] empty
);

    logic [STOCK_W-1:0] cnt_q [NUM_PROD];
    logic [STOCK_W-1:0] cnt_d [NUM_PROD];

    // Next stock level per product and empty flags from the current level.
    always_comb begin
        for (int i = 0; i < NUM_PROD; i++) begin
            if (restock) begin
                cnt_d[i] = STOCK_W'(STOCK_MAX);
            end else if (dec && (dec_sel == 2'(i + 1)) && (cnt_q[i] != 3'd0)) begin
                cnt_d[i] = cnt_q[i] - 3'd1;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
            empty[i] = (cnt_q[i] == 3'd0);
        end
    end

    // Stock registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PROD; i++) begin
            if (rst) begin
                cnt_q[i] <= STOCK_W'(STOCK_MAX);
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// Vending machine transaction sequencer: coin acceptance, product selection,
// motor dispense handshake, change payout and inactivity refund.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int TIMEOUT   = 200,
    parameter int STOCK_MAX = 7
) (
    input  logic clk,
    input  logic rst,
    vend_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credito_q, credito_d;
    logic [CNT_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic                motor_req_q, motor_req_d;
    logic [1:0]          producto_q, producto_d;
    logic                coin_req_q, coin_req_d;
    logic                listo_q, listo_d;
    logic                coin_reject_q, coin_reject_d;
    logic                agotado_q, agotado_d;
    logic                fondos_insuf_q, fondos_insuf_d;

    logic [NUM_PROD-1:0] empty_s;
    logic [3:0]          prod_empty_s;
    logic                sel_empty_s;
    logic                sel_hit_s;
    logic                buy_s;
    logic                stock_dec_s;
    logic [CREDIT_W-1:0] coin_val_s;
    logic [CREDIT_W-1:0] cost_s;
    logic [CREDIT_W:0]   base_s;

    vend_stock #(.STOCK_MAX(STOCK_MAX)) u_stock (
        .clk     (clk),
        .rst     (rst),
        .restock (bus.restock),
        .dec     (stock_dec_s),
        .dec_sel (bus.seleccion),
        .empty   (empty_s)
    );

    // Selection decode; entry 0 stands for the ignored 00 code and is never empty.
    always_comb begin
        prod_empty_s = {empty_s, 1'b0};
        sel_empty_s  = prod_empty_s[bus.seleccion];
        sel_hit_s    = bus.sel_valid && (bus.seleccion != 2'b00);
        coin_val_s   = coin_value(bus.moneda);
        cost_s       = product_cost(bus.seleccion);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        credito_d      = credito_q;
        idle_cnt_d     = idle_cnt_q;
        motor_req_d    = motor_req_q;
        producto_d     = producto_q;
        coin_req_d     = coin_req_q;
        listo_d        = 1'b0;
        coin_reject_d  = 1'b0;
        agotado_d      = 1'b0;
        fondos_insuf_d = 1'b0;
        buy_s          = 1'b0;
        stock_dec_s    = 1'b0;
        base_s         = {1'b0, credito_q};

        case (state_q)
            ST_IDLE: begin
                idle_cnt_d = '0;
                if (bus.moneda_valid) begin
                    if ((coin_val_s == 5'd0) || ((base_s + {1'b0, coin_val_s}) > {1'b0, CREDIT_MAX})) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credito_d = credito_q + coin_val_s;
                        state_d   = ST_CREDITO;
                    end
                end else begin
                    coin_reject_d = 1'b0;
                end
                fondos_insuf_d = sel_hit_s;
            end

            ST_CREDITO: begin
                // Selection is judged on the credit held before any same-cycle coin.
                if (sel_hit_s && !bus.cancelar) begin
                    if (sel_empty_s) begin
                        agotado_d = 1'b1;
                    end else if (credito_q < cost_s) begin
                        fondos_insuf_d = 1'b1;
                    end else begin
                        buy_s = 1'b1;
                    end
                end else begin
                    buy_s = 1'b0;
                end

                if (buy_s) begin
                    base_s      = {1'b0, credito_q - cost_s};
                    stock_dec_s = 1'b1;
                end else begin
                    base_s = {1'b0, credito_q};
                end

                if (bus.moneda_valid) begin
                    if ((coin_val_s == 5'd0) || ((base_s + {1'b0, coin_val_s}) > {1'b0, CREDIT_MAX})) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        base_s = base_s + {1'b0, coin_val_s};
                    end
                end else begin
                    coin_reject_d = 1'b0;
                end
                credito_d = base_s[CREDIT_W-1:0];

                if (bus.cancelar) begin
                    state_d    = ST_CAMBIO;
                    coin_req_d = 1'b1;
                    idle_cnt_d = '0;
                end else if (buy_s) begin
                    state_d     = ST_DISPENSA;
                    motor_req_d = 1'b1;
                    producto_d  = bus.seleccion;
                    idle_cnt_d  = '0;
                end else if (bus.moneda_valid || sel_hit_s) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d    = ST_CAMBIO;
                    coin_req_d = 1'b1;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end

            ST_DISPENSA: begin
                coin_reject_d = bus.moneda_valid;
                if (bus.motor_ack) begin
                    motor_req_d = 1'b0;
                    producto_d  = 2'b00;
                    if (credito_q != 5'd0) begin
                        state_d    = ST_CAMBIO;
                        coin_req_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        listo_d = 1'b1;
                    end
                end else begin
                    motor_req_d = 1'b1;
                end
            end

            ST_CAMBIO: begin
                coin_reject_d = bus.moneda_valid;
                if (bus.coin_ack) begin
                    credito_d = credito_q - 5'd1;
                    if (credito_q == 5'd1) begin
                        state_d    = ST_IDLE;
                        coin_req_d = 1'b0;
                        listo_d    = 1'b1;
                    end else begin
                        coin_req_d = 1'b1;
                    end
                end else begin
                    coin_req_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                credito_d   = 5'd0;
                idle_cnt_d  = '0;
                motor_req_d = 1'b0;
                producto_d  = 2'b00;
                coin_req_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            credito_q      <= 5'd0;
            idle_cnt_q     <= '0;
            motor_req_q    <= 1'b0;
            producto_q     <= 2'b00;
            coin_req_q     <= 1'b0;
            listo_q        <= 1'b0;
            coin_reject_q  <= 1'b0;
            agotado_q      <= 1'b0;
            fondos_insuf_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            credito_q      <= credito_d;
            idle_cnt_q     <= idle_cnt_d;
            motor_req_q    <= motor_req_d;
            producto_q     <= producto_d;
            coin_req_q     <= coin_req_d;
            listo_q        <= listo_d;
            coin_reject_q  <= coin_reject_d;
            agotado_q      <= agotado_d;
            fondos_insuf_q <= fondos_insuf_d;
        end
    end

    assign bus.motor_req    = motor_req_q;
    assign bus.producto     = producto_q;
    assign bus.coin_req     = coin_req_q;
    assign bus.credito      = credito_q;
    assign bus.listo        = listo_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.agotado      = agotado_q;
    assign bus.fondos_insuf = fondos_insuf_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed scenarios with literal
// expectations plus a randomized run against a behavioural transaction model.
module tb_vend_sequencer;

    localparam int TIMEOUT   = 10;
    localparam int STOCK_MAX = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    vend_if bus ();

    vend_sequencer #(.TIMEOUT(TIMEOUT), .STOCK_MAX(STOCK_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: 0 waiting, 1 holding credit, 2 dispensing, 3 paying change.
    int m_mode, m_credit, m_idle, m_prod;
    int m_stock [3];
    bit m_listo, m_rej, m_ago, m_fi;

    task automatic model_clock();
        int coin, cost, sel, c;
        bit hit, buy;
        m_listo = 0; m_rej = 0; m_ago = 0; m_fi = 0;
        if (rst) begin
            m_mode = 0; m_credit = 0; m_idle = 0; m_prod = 0;
            for (int i = 0; i < 3; i++) m_stock[i] = STOCK_MAX;
            return;
        end
        coin = (bus.moneda >= 2) ? int'(bus.moneda) : 0;
        sel  = int'(bus.seleccion);
        hit  = bus.sel_valid && (sel != 0);
        cost = (sel == 1) ? 4 : (sel == 2) ? 7 : 9;
        buy  = 0;
        case (m_mode)
            0: begin
                if (bus.moneda_valid) begin
                    if (coin == 0 || m_credit + coin > 31) m_rej = 1;
                    else begin m_credit += coin; m_mode = 1; end
                end
                if (hit) m_fi = 1;
            end
            1: begin
                c = m_credit;
                if (hit && !bus.cancelar) begin
                    if (m_stock[sel-1] == 0) m_ago = 1;
                    else if (m_credit < cost) m_fi = 1;
                    else buy = 1;
                end
                if (buy) begin c -= cost; m_stock[sel-1]--; end
                if (bus.moneda_valid) begin
                    if (coin == 0 || c + coin > 31) m_rej = 1;
                    else c += coin;
                end
                m_credit = c;
                if (bus.cancelar) begin m_mode = 3; m_idle = 0; end
                else if (buy) begin m_mode = 2; m_prod = sel; m_idle = 0; end
                else if (bus.moneda_valid || hit) m_idle = 0;
                else begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin m_mode = 3; m_idle = 0; end
                end
            end
            2: begin
                if (bus.moneda_valid) m_rej = 1;
                if (bus.motor_ack) begin
                    m_prod = 0;
                    if (m_credit > 0) m_mode = 3;
                    else begin m_mode = 0; m_listo = 1; end
                end
            end
            default: begin
                if (bus.moneda_valid) m_rej = 1;
                if (bus.coin_ack) begin
                    m_credit--;
                    if (m_credit == 0) begin m_mode = 0; m_listo = 1; end
                end
            end
        endcase
        if (bus.restock) for (int i = 0; i < 3; i++) m_stock[i] = STOCK_MAX;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic clear_inputs();
        bus.moneda = 2'd0; bus.moneda_valid = 1'b0;
        bus.seleccion = 2'd0; bus.sel_valid = 1'b0;
        bus.cancelar = 1'b0; bus.restock = 1'b0;
        bus.motor_ack = 1'b0; bus.coin_ack = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic coin(input logic [1:0] code);
        bus.moneda = code; bus.moneda_valid = 1'b1;
        tick();
        bus.moneda_valid = 1'b0;
    endtask

    task automatic select(input logic [1:0] s);
        bus.seleccion = s; bus.sel_valid = 1'b1;
        tick();
        bus.sel_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (bus.credito !== 5'd0) begin n_err++; $display("FAIL reset_credito got %0d want 0", bus.credito); end
        n_vec++; if (bus.motor_req !== 1'b0) begin n_err++; $display("FAIL reset_motor_req got %b want 0", bus.motor_req); end
        n_vec++; if (bus.coin_req !== 1'b0) begin n_err++; $display("FAIL reset_coin_req got %b want 0", bus.coin_req); end
        n_vec++; if (bus.producto !== 2'b00) begin n_err++; $display("FAIL reset_producto got %b want 00", bus.producto); end
        n_vec++; if ({bus.listo, bus.coin_reject, bus.agotado, bus.fondos_insuf} !== 4'b0000) begin
            n_err++; $display("FAIL reset_pulses got %b want 0000", {bus.listo, bus.coin_reject, bus.agotado, bus.fondos_insuf}); end
    endtask

    task automatic test_purchase();
        do_reset();
        coin(2'd3);
        coin(2'd2);
        n_vec++; if (bus.credito !== 5'd5) begin n_err++; $display("FAIL buy_credit5 got %0d want 5", bus.credito); end
        select(2'b01);
        n_vec++; if (bus.credito !== 5'd1) begin n_err++; $display("FAIL buy_credit1 got %0d want 1", bus.credito); end
        n_vec++; if (bus.motor_req !== 1'b1) begin n_err++; $display("FAIL buy_motor_req got %b want 1", bus.motor_req); end
        n_vec++; if (bus.producto !== 2'b01) begin n_err++; $display("FAIL buy_producto got %b want 01", bus.producto); end
        tick();
        n_vec++; if (bus.motor_req !== 1'b1) begin n_err++; $display("FAIL buy_motor_hold got %b want 1", bus.motor_req); end
        bus.motor_ack = 1'b1; tick(); bus.motor_ack = 1'b0;
        n_vec++; if ({bus.motor_req, bus.producto} !== 3'b000) begin n_err++; $display("FAIL buy_motor_release got %b want 000", {bus.motor_req, bus.producto}); end
        n_vec++; if (bus.coin_req !== 1'b1) begin n_err++; $display("FAIL buy_change_req got %b want 1", bus.coin_req); end
        n_vec++; if (bus.listo !== 1'b0) begin n_err++; $display("FAIL buy_no_early_listo got %b want 0", bus.listo); end
        bus.coin_ack = 1'b1; tick(); bus.coin_ack = 1'b0;
        n_vec++; if (bus.credito !== 5'd0) begin n_err++; $display("FAIL buy_change_done got %0d want 0", bus.credito); end
        n_vec++; if ({bus.coin_req, bus.listo} !== 2'b01) begin n_err++; $display("FAIL buy_listo got %b want 01", {bus.coin_req, bus.listo}); end
        tick();
        n_vec++; if (bus.listo !== 1'b0) begin n_err++; $display("FAIL buy_listo_pulse got %b want 0", bus.listo); end
    endtask

    task automatic test_insufficient_cancel();
        do_reset();
        coin(2'd2);
        coin(2'd2);
        select(2'b11);
        n_vec++; if (bus.fondos_insuf !== 1'b1) begin n_err++; $display("FAIL insuf_pulse got %b want 1", bus.fondos_insuf); end
        n_vec++; if ({bus.credito, bus.motor_req} !== {5'd4, 1'b0}) begin n_err++; $display("FAIL insuf_keep got %0d/%b want 4/0", bus.credito, bus.motor_req); end
        bus.cancelar = 1'b1; tick(); bus.cancelar = 1'b0;
        n_vec++; if (bus.coin_req !== 1'b1) begin n_err++; $display("FAIL cancel_coin_req got %b want 1", bus.coin_req); end
        for (int i = 0; i < 4; i++) begin
            bus.coin_ack = 1'b1; tick(); bus.coin_ack = 1'b0;
            n_vec++; if (bus.credito !== 5'(3 - i)) begin n_err++; $display("FAIL refund_step%0d got %0d want %0d", i, bus.credito, 3 - i); end
        end
        n_vec++; if ({bus.coin_req, bus.listo} !== 2'b01) begin n_err++; $display("FAIL refund_listo got %b want 01", {bus.coin_req, bus.listo}); end
    endtask

    task automatic test_stock();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin coin(2'd2); coin(2'd2); end
            select(2'b01);
            if (i < 7) begin
                n_vec++; if (bus.motor_req !== 1'b1) begin n_err++; $display("FAIL stock_buy%0d motor_req got %b want 1", i, bus.motor_req); end
                bus.motor_ack = 1'b1; tick(); bus.motor_ack = 1'b0;
                n_vec++; if (bus.listo !== 1'b1) begin n_err++; $display("FAIL stock_buy%0d listo got %b want 1", i, bus.listo); end
            end else begin
                n_vec++; if ({bus.agotado, bus.fondos_insuf, bus.motor_req} !== 3'b100) begin
                    n_err++; $display("FAIL stock_empty%0d flags got %b want 100", i, {bus.agotado, bus.fondos_insuf, bus.motor_req}); end
                n_vec++; if (bus.credito !== 5'd4) begin n_err++; $display("FAIL stock_empty%0d credito got %0d want 4", i, bus.credito); end
            end
        end
        bus.restock = 1'b1; tick(); bus.restock = 1'b0;
        select(2'b01);
        n_vec++; if ({bus.motor_req, bus.producto, bus.credito} !== {1'b1, 2'b01, 5'd0}) begin
            n_err++; $display("FAIL restock_buy got %b/%b/%0d want 1/01/0", bus.motor_req, bus.producto, bus.credito); end
    endtask

    task automatic test_coin_reject();
        do_reset();
        for (int i = 0; i < 10; i++) coin(2'd3);
        n_vec++; if (bus.credito !== 5'd30) begin n_err++; $display("FAIL rej_credit30 got %0d want 30", bus.credito); end
        coin(2'd3);
        n_vec++; if ({bus.coin_reject, bus.credito} !== {1'b1, 5'd30}) begin n_err++; $display("FAIL rej_overflow got %b/%0d want 1/30", bus.coin_reject, bus.credito); end
        tick();
        n_vec++; if (bus.coin_reject !== 1'b0) begin n_err++; $display("FAIL rej_pulse got %b want 0", bus.coin_reject); end
        coin(2'd0);
        n_vec++; if ({bus.coin_reject, bus.credito} !== {1'b1, 5'd30}) begin n_err++; $display("FAIL rej_code0 got %b/%0d want 1/30", bus.coin_reject, bus.credito); end
        select(2'b11);
        n_vec++; if ({bus.motor_req, bus.credito} !== {1'b1, 5'd21}) begin n_err++; $display("FAIL rej_buy_c got %b/%0d want 1/21", bus.motor_req, bus.credito); end
        coin(2'd2);
        n_vec++; if ({bus.coin_reject, bus.credito, bus.motor_req} !== {1'b1, 5'd21, 1'b1}) begin
            n_err++; $display("FAIL rej_dispensa got %b/%0d/%b want 1/21/1", bus.coin_reject, bus.credito, bus.motor_req); end
    endtask

    task automatic test_same_cycle_and_timeout();
        do_reset();
        coin(2'd2);
        coin(2'd2);
        bus.moneda = 2'd3; bus.moneda_valid = 1'b1;
        select(2'b01);
        bus.moneda_valid = 1'b0;
        n_vec++; if ({bus.motor_req, bus.credito, bus.coin_reject} !== {1'b1, 5'd3, 1'b0}) begin
            n_err++; $display("FAIL same_cycle got %b/%0d/%b want 1/3/0", bus.motor_req, bus.credito, bus.coin_reject); end
        do_reset();
        coin(2'd2);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        n_vec++; if ({bus.coin_req, bus.credito} !== {1'b0, 5'd2}) begin n_err++; $display("FAIL timeout_early got %b/%0d want 0/2", bus.coin_req, bus.credito); end
        tick();
        n_vec++; if (bus.coin_req !== 1'b1) begin n_err++; $display("FAIL timeout_refund got %b want 1", bus.coin_req); end
    endtask

    task automatic test_reset_mid_cambio();
        do_reset();
        coin(2'd3);
        coin(2'd2);
        bus.cancelar = 1'b1; tick(); bus.cancelar = 1'b0;
        n_vec++; if ({bus.coin_req, bus.credito} !== {1'b1, 5'd5}) begin n_err++; $display("FAIL mid_cambio got %b/%0d want 1/5", bus.coin_req, bus.credito); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_vec++; if ({bus.coin_req, bus.credito} !== {1'b0, 5'd0}) begin n_err++; $display("FAIL rst_cambio got %b/%0d want 0/0", bus.coin_req, bus.credito); end
        select(2'b01);
        n_vec++; if ({bus.fondos_insuf, bus.motor_req} !== 2'b10) begin n_err++; $display("FAIL rst_idle got %b want 10", {bus.fondos_insuf, bus.motor_req}); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            bus.moneda       = 2'($urandom_range(0, 3));
            bus.moneda_valid = ($urandom_range(0, 99) < 30);
            bus.seleccion    = 2'($urandom_range(0, 3));
            bus.sel_valid    = ($urandom_range(0, 99) < 20);
            bus.cancelar     = ($urandom_range(0, 99) < 4);
            bus.restock      = ($urandom_range(0, 99) < 2);
            bus.motor_ack    = ($urandom_range(0, 99) < 40);
            bus.coin_ack     = ($urandom_range(0, 99) < 50);
            rst              = ($urandom_range(0, 999) < 3);
            tick();
            n_vec++; if (bus.credito !== 5'(m_credit)) begin n_err++; $display("FAIL rnd%0d credito got %0d want %0d", n, bus.credito, m_credit); end
            n_vec++; if (bus.motor_req !== (m_mode == 2)) begin n_err++; $display("FAIL rnd%0d motor_req got %b want %b", n, bus.motor_req, m_mode == 2); end
            n_vec++; if (bus.coin_req !== (m_mode == 3)) begin n_err++; $display("FAIL rnd%0d coin_req got %b want %b", n, bus.coin_req, m_mode == 3); end
            n_vec++; if (bus.producto !== 2'(m_prod)) begin n_err++; $display("FAIL rnd%0d producto got %0d want %0d", n, bus.producto, m_prod); end
            n_vec++; if (bus.listo !== m_listo) begin n_err++; $display("FAIL rnd%0d listo got %b want %b", n, bus.listo, m_listo); end
            n_vec++; if (bus.coin_reject !== m_rej) begin n_err++; $display("FAIL rnd%0d coin_reject got %b want %b", n, bus.coin_reject, m_rej); end
            n_vec++; if (bus.agotado !== m_ago) begin n_err++; $display("FAIL rnd%0d agotado got %b want %b", n, bus.agotado, m_ago); end
            n_vec++; if (bus.fondos_insuf !== m_fi) begin n_err++; $display("FAIL rnd%0d fondos_insuf got %b want %b", n, bus.fondos_insuf, m_fi); end
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_purchase();
        test_insufficient_cancel();
        test_stock();
        test_coin_reject();
        test_same_cycle_and_timeout();
        test_reset_mid_cambio();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
